// File: rtl/bnn_xnor_popcnt.sv
// Binary-NN neuron datapath: accumulates popcount(XNOR(act, wgt)) over N_WORDS beats per
// neuron, thresholds each sum to one bit, and packs 32 bits LSB-first into an output word.
module bnn_xnor_popcnt #(
    parameter int N_WORDS = 4,
    parameter int ACC_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      cfg_neurons,
    input  logic [ACC_W-1:0] cfg_thresh,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_act,
    input  logic [31:0]      in_wgt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_word,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int WC_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [WC_W-1:0]  word_cnt;
    logic [4:0]       bit_cnt;
    logic [15:0]      neuron_cnt;
    logic [31:0]      shreg;
    logic [15:0]      neurons_q;
    logic [ACC_W-1:0] thresh_q;

    logic [5:0]       pc;
    logic [ACC_W-1:0] sum;
    logic             neuron_bit;
    logic             last_beat;
    logic             final_neuron;
    logic [31:0]      new_shreg;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

    always_comb begin
        pc           = popcount32(~(in_act ^ in_wgt));
        sum          = acc + ACC_W'(pc);
        neuron_bit   = (sum >= thresh_q);
        last_beat    = (word_cnt == WC_W'(N_WORDS - 1));
        final_neuron = (neuron_cnt == neurons_q - 16'd1);
        new_shreg    = shreg | ({31'd0, neuron_bit} << bit_cnt);
    end

    assign in_ready = (state == RUN);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            word_cnt   <= '0;
            bit_cnt    <= '0;
            neuron_cnt <= '0;
            shreg      <= '0;
            neurons_q  <= '0;
            thresh_q   <= '0;
            out_valid  <= 1'b0;
            out_word   <= '0;
            out_last   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        neurons_q  <= cfg_neurons;
                        thresh_q   <= cfg_thresh;
                        acc        <= '0;
                        word_cnt   <= '0;
                        bit_cnt    <= '0;
                        neuron_cnt <= '0;
                        shreg      <= '0;
                        state      <= (cfg_neurons == 16'd0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        if (last_beat) begin
                            acc        <= '0;
                            word_cnt   <= '0;
                            neuron_cnt <= neuron_cnt + 16'd1;
                            bit_cnt    <= bit_cnt + 5'd1;
                            // A full word or the job's last neuron flushes the packer.
                            if (bit_cnt == 5'd31 || final_neuron) begin
                                out_word  <= new_shreg;
                                out_valid <= 1'b1;
                                out_last  <= final_neuron;
                                shreg     <= '0;
                                state     <= HOLD;
                            end else begin
                                shreg <= new_shreg;
                            end
                        end else begin
                            acc      <= sum;
                            word_cnt <= word_cnt + WC_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= out_last ? DONE : RUN;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_xnor_popcnt.sv
// Self-checking bench for bnn_xnor_popcnt: directed jobs push expected words into a
// scoreboard queue that a separate monitor pops on every output handshake.
module tb_bnn_xnor_popcnt;

    localparam int N_WORDS = 4;
    localparam int ACC_W   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [15:0]      cfg_neurons;
    logic [ACC_W-1:0] cfg_thresh;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_act;
    logic [31:0]      in_wgt;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_word;
    logic             out_last;
    logic             busy;
    logic             done;

    typedef struct packed {
        logic [31:0] word;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    bnn_xnor_popcnt #(.N_WORDS(N_WORDS), .ACC_W(ACC_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_neurons (cfg_neurons),
        .cfg_thresh  (cfg_thresh),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_act      (in_act),
        .in_wgt      (in_wgt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_word    (out_word),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, required);
        end
    endtask

    // Scoreboard monitor: one pop per output handshake, sampled mid-cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_word: got 0x%08h last=%0b, expected no transfer", out_word, out_last);
            end else begin
                e = exp_q.pop_front();
                checkOutput("out_word", out_word, e.word);
                checkOutput("out_last", {31'd0, out_last}, {31'd0, e.last});
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] w);
        bit accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_act   = a;
        in_wgt   = w;
        for (int k = 0; k < 200 && !accepted; k++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_timeout: got in_ready=0 for 200 cycles, expected acceptance");
        end
    endtask

    task automatic send_neuron(input bit match, input logic [31:0] seed);
        for (int i = 0; i < N_WORDS; i++) begin
            if (match) applyStimulus(seed + 32'(i), seed + 32'(i));
            else       applyStimulus(seed + 32'(i), ~(seed + 32'(i)));
        end
    endtask

    task automatic start_job(input logic [15:0] n, input logic [ACC_W-1:0] th);
        cfg_neurons = n;
        cfg_thresh  = th;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 500 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checkOutput(name, {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected completion within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        cfg_neurons = '0;
        cfg_thresh  = '0;
        in_valid    = 1'b0;
        in_act      = '0;
        in_wgt      = '0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready",  {31'd0, in_ready},  32'd0);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_word",  out_word,           32'd0);
        checkOutput("rst_busy",      {31'd0, busy},      32'd0);
        checkOutput("rst_done",      {31'd0, done},      32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // One neuron, all 128 bits match, sum 128 >= 128.
        exp_q.push_back('{word: 32'h0000_0001, last: 1'b1});
        start_job(16'd1, 8'd128);
        send_neuron(1'b1, 32'h1234_5678);
        checkOutput("t1_latency", {31'd0, out_valid}, 32'd1);
        wait_done("t1_done");

        // Sum 0 against thresholds 0 and 1.
        exp_q.push_back('{word: 32'h0000_0001, last: 1'b1});
        start_job(16'd1, 8'd0);
        for (int i = 0; i < N_WORDS; i++) applyStimulus(32'hFFFF_FFFF, 32'h0);
        wait_done("t2a_done");
        exp_q.push_back('{word: 32'h0000_0000, last: 1'b1});
        start_job(16'd1, 8'd1);
        for (int i = 0; i < N_WORDS; i++) applyStimulus(32'hFFFF_FFFF, 32'h0);
        wait_done("t2b_done");

        // Alternating match/mismatch neurons across a full word.
        exp_q.push_back('{word: 32'h5555_5555, last: 1'b1});
        start_job(16'd32, 8'd64);
        for (int n = 0; n < 32; n++) send_neuron(n % 2 == 0, 32'hA5A5_0F0F + 32'(n));
        wait_done("t3_done");

        // 33 neurons: bit counter wraps into a second word.
        exp_q.push_back('{word: 32'hFFFF_FFFF, last: 1'b0});
        exp_q.push_back('{word: 32'h0000_0001, last: 1'b1});
        start_job(16'd33, 8'd0);
        for (int n = 0; n < 33; n++) send_neuron(1'b1, 32'h0BAD_F00D + 32'(n));
        wait_done("t4_done");

        // Back-pressure in HOLD: offered mismatching beats must not be consumed.
        out_ready = 1'b0;
        exp_q.push_back('{word: 32'hFFFF_FFFF, last: 1'b0});
        exp_q.push_back('{word: 32'h0000_0001, last: 1'b1});
        start_job(16'd33, 8'd128);
        for (int n = 0; n < 32; n++) send_neuron(1'b1, 32'hC0DE_0000 + 32'(n));
        checkOutput("t5_hold_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b1;
        in_act   = 32'h0;
        in_wgt   = 32'hFFFF_FFFF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("t5_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("t5_word_stable", out_word, 32'hFFFF_FFFF);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send_neuron(1'b1, 32'h7777_0000);
        checkOutput("t5_resume_valid", {31'd0, out_valid}, 32'd1);
        wait_done("t5_done");

        // Empty job: straight to DONE.
        start_job(16'd0, 8'd0);
        checkOutput("t6_busy",  {31'd0, busy},      32'd1);
        checkOutput("t6_done",  {31'd0, done},      32'd1);
        checkOutput("t6_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("t6_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("t6_idle_done", {31'd0, done}, 32'd0);

        // Reset mid-RUN aborts the partial job.
        start_job(16'd2, 8'd0);
        applyStimulus(32'h1111_1111, 32'h1111_1111);
        applyStimulus(32'h2222_2222, 32'h2222_2222);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t6_rst_in_ready",  {31'd0, in_ready},  32'd0);
        checkOutput("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("t6_rst_out_word",  out_word,           32'd0);
        checkOutput("t6_rst_out_last",  {31'd0, out_last},  32'd0);
        checkOutput("t6_rst_busy",      {31'd0, busy},      32'd0);
        checkOutput("t6_rst_done",      {31'd0, done},      32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back('{word: 32'h0000_0001, last: 1'b1});
        start_job(16'd1, 8'd128);
        send_neuron(1'b1, 32'h3C3C_3C3C);
        wait_done("t6_fresh_done");

        repeat (3) @(posedge clk);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
